id_fwd_stage: RTL and testbench

- Parametrised next-generation decode front end. Sits between IF and EX.
- Owns the IF→ID pipeline register and holds the synchronous-SRAM instruction across stalls.
- Resolves operands through an N-source forwarding network in front of an external regfile, and raises load-use interlock requests.
- Resolves branches/jumps in ID and tracks delay-slot status.

---
 rtl/id_fwd_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_id_fwd_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/id_fwd_stage.sv
// -----------------------------------------------------------------------------
// id_fwd_stage : decode front end between IF and EX.
//
// Owns the IF->ID pipeline register. It also keeps the synchronous-SRAM
// instruction word stable while ID is stalled, because the SRAM output moves
// on to later fetches during that time.
//
// Each source operand is resolved through a priority forwarding network that
// sits in front of an external regfile. The block raises a load-use interlock
// request, resolves branches and jumps in ID, and tracks delay-slot status.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall               global stall bus: bit1 = ID hold, bit2 = EX hold
//   flush               kill the instruction entering ID at the next edge
//   if_valid, if_pc     fetch payload captured into ID
//   inst_sram_rdata     instruction word, valid the cycle after the fetch
//   fwd_we/waddr/wdata  NUM_FWD forwarding sources, index 0 = highest priority
//   ex_is_load,
//   ex_load_waddr       load currently in EX, used for the interlock
//   rf_raddr1/2         regfile read addresses (rs, rt), combinational
//   rf_rdata1/2         regfile read data, combinational
//   id_valid, id_pc,
//   id_inst             live instruction in ID (id_inst is 0 when not valid)
//   src1/src2_data      forwarded rs/rt operands
//   id_in_delay_slot    ID instruction follows a valid branch/jump
//   stallreq            load-use interlock request
//   br_taken, br_target IF redirect
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module id_fwd_stage #(
    parameter int DATA_W  = 32,
    parameter int RA_W    = 5,
    parameter int NUM_FWD = 3,
    parameter int STALL_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic                      if_valid,
    input  logic [DATA_W-1:0]         if_pc,
    input  logic [31:0]               inst_sram_rdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*RA_W-1:0]   fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic                      ex_is_load,
    input  logic [RA_W-1:0]           ex_load_waddr,
    output logic [RA_W-1:0]           rf_raddr1,
    output logic [RA_W-1:0]           rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    output logic                      id_valid,
    output logic [DATA_W-1:0]         id_pc,
    output logic [31:0]               id_inst,
    output logic [DATA_W-1:0]         src1_data,
    output logic [DATA_W-1:0]         src2_data,
    output logic                      id_in_delay_slot,
    output logic                      stallreq,
    output logic                      br_taken,
    output logic [DATA_W-1:0]         br_target
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    // Bus bits 0 and 3+ belong to other stages.
    logic stall_unused;
    assign stall_unused = ^{stall[STALL_W-1:3], stall[0]};

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              delay_q, delay_d;
    logic              hold_vld_q, hold_vld_d;
    logic [31:0]       inst_hold_q, inst_hold_d;

    logic              is_br_s;
    logic              take_s;
    logic [DATA_W-1:0] tgt_s;
    logic              use_rs_s, use_rt_s;

    // Resolve one operand. The lowest matching index wins, and r0 is forced to 0.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [RA_W-1:0]           addr,
        input logic [DATA_W-1:0]         rf_data,
        input logic [NUM_FWD-1:0]        we,
        input logic [NUM_FWD*RA_W-1:0]   waddr,
        input logic [NUM_FWD*DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] r;
        r = rf_data;
        // Walk from the lowest priority to the highest so that index 0 overrides.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            r = (we[i] && (waddr[i*RA_W +: RA_W] == addr)) ? wdata[i*DATA_W +: DATA_W] : r;
        end
        return (addr == '0) ? '0 : r;
    endfunction

    // Effective instruction, register addressing and forwarded operands.
    always_comb begin
        if (!valid_q) begin
            id_inst = 32'h0000_0000;
        end else if (hold_vld_q) begin
            id_inst = inst_hold_q;
        end else begin
            id_inst = inst_sram_rdata;
        end
        rf_raddr1 = RA_W'(id_inst[25:21]);
        rf_raddr2 = RA_W'(id_inst[20:16]);
        src1_data = fwd_sel(rf_raddr1, rf_rdata1, fwd_we, fwd_waddr, fwd_wdata);
        src2_data = fwd_sel(rf_raddr2, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata);
    end

    // Source usage and the load-use interlock.
    always_comb begin
        use_rs_s = !((id_inst[31:26] == OP_J) || (id_inst[31:26] == OP_JAL) ||
                     (id_inst[31:26] == OP_LUI));
        use_rt_s = (id_inst[31:26] == OP_SPECIAL) || (id_inst[31:26] == OP_BEQ) ||
                   (id_inst[31:26] == OP_BNE) || (id_inst[31:29] == 3'b101);
        stallreq = valid_q && ex_is_load && (ex_load_waddr != '0) &&
                   ((use_rs_s && (ex_load_waddr == rf_raddr1)) ||
                    (use_rt_s && (ex_load_waddr == rf_raddr2)));
    end

    // Branch/jump classification, condition evaluation and target selection.
    always_comb begin
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] cond_tgt;
        logic [DATA_W-1:0] jmp_tgt;
        pc_plus4 = pc_q + DATA_W'(4);
        cond_tgt = pc_plus4 + {{(DATA_W-18){id_inst[15]}}, id_inst[15:0], 2'b00};
        jmp_tgt  = {pc_plus4[DATA_W-1:28], id_inst[25:0], 2'b00};
        is_br_s  = 1'b0;
        take_s   = 1'b0;
        tgt_s    = cond_tgt;
        case (id_inst[31:26])
            OP_SPECIAL: begin
                if ((id_inst[5:0] == FN_JR) || (id_inst[5:0] == FN_JALR)) begin
                    is_br_s = 1'b1;
                    take_s  = 1'b1;
                    tgt_s   = src1_data;
                end else begin
                    is_br_s = 1'b0;
                end
            end
            OP_REGIMM: begin
                case (id_inst[20:16])
                    5'b00000: begin is_br_s = 1'b1; take_s = src1_data[DATA_W-1];  end
                    5'b00001: begin is_br_s = 1'b1; take_s = !src1_data[DATA_W-1]; end
                    default:  begin is_br_s = 1'b0; take_s = 1'b0;                 end
                endcase
            end
            OP_J, OP_JAL: begin
                is_br_s = 1'b1;
                take_s  = 1'b1;
                tgt_s   = jmp_tgt;
            end
            OP_BEQ:  begin is_br_s = 1'b1; take_s = (src1_data == src2_data); end
            OP_BNE:  begin is_br_s = 1'b1; take_s = (src1_data != src2_data); end
            OP_BLEZ: begin is_br_s = 1'b1; take_s = src1_data[DATA_W-1] || (src1_data == '0); end
            OP_BGTZ: begin is_br_s = 1'b1; take_s = !src1_data[DATA_W-1] && (src1_data != '0); end
            default: begin is_br_s = 1'b0; take_s = 1'b0; end
        endcase
        // A redirect is only trusted once the operands are final.
        br_taken  = valid_q && !stallreq && take_s;
        br_target = br_taken ? tgt_s : '0;
    end

    // Next state of the pipeline register, the delay flag and the instruction hold.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        delay_d     = delay_q;
        hold_vld_d  = hold_vld_q;
        inst_hold_d = inst_hold_q;
        if (rst) begin
            valid_d = 1'b0;
            pc_d    = '0;
            delay_d = 1'b0;
        end else if (flush || (stall[1] && !stall[2])) begin
            valid_d = 1'b0;
            pc_d    = '0;
            delay_d = 1'b0;
        end else if (!stall[1]) begin
            valid_d = if_valid;
            pc_d    = if_pc;
            delay_d = valid_q && is_br_s;
        end else begin
            valid_d = valid_q;
        end
        if (rst || flush || !stall[1]) begin
            hold_vld_d  = 1'b0;
            inst_hold_d = rst ? 32'h0000_0000 : inst_hold_q;
        end else if (!hold_vld_q) begin
            // First stalled cycle: capture the word before the SRAM moves on.
            hold_vld_d  = 1'b1;
            inst_hold_d = inst_sram_rdata;
        end else begin
            hold_vld_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        valid_q     <= valid_d;
        pc_q        <= pc_d;
        delay_q     <= delay_d;
        hold_vld_q  <= hold_vld_d;
        inst_hold_q <= inst_hold_d;
    end

    assign id_valid         = valid_q;
    assign id_pc            = pc_q;
    assign id_in_delay_slot = delay_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
`timescale 1ns/1ps
module tb_id_fwd_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] inst_sram_rdata;
    logic [2:0]  fwd_we;
    logic [14:0] fwd_waddr;
    logic [95:0] fwd_wdata;
    logic        ex_is_load;
    logic [4:0]  ex_load_waddr;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        id_valid;
    logic [31:0] id_pc, id_inst, src1_data, src2_data, br_target;
    logic        id_in_delay_slot, stallreq, br_taken;

    logic [31:0] rf [32];
    int compared   = 0;
    int mismatched = 0;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    id_fwd_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .ex_is_load(ex_is_load), .ex_load_waddr(ex_load_waddr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .src1_data(src1_data), .src2_data(src2_data),
        .id_in_delay_slot(id_in_delay_slot), .stallreq(stallreq),
        .br_taken(br_taken), .br_target(br_target)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0000_0000;
        rst = 1'b1; stall = 6'b000000; flush = 1'b0;
        if_valid = 1'b0; if_pc = 32'h0000_0000; inst_sram_rdata = 32'hFFFF_FFFF;
        fwd_we = 3'b000; fwd_waddr = 15'h0000; fwd_wdata = 96'h0;
        ex_is_load = 1'b0; ex_load_waddr = 5'd0;

        // Reset state
        tick(); tick();
        rst = 1'b0; #1;
        check("rst_valid", id_valid, 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_inst", id_inst, 32'd0);
        check("rst_dslot", id_in_delay_slot, 32'd0);
        check("rst_stallreq", stallreq, 32'd0);
        check("rst_br", br_taken, 32'd0);
        check("rst_tgt", br_target, 32'd0);

        // Forward priority: addu r9,r8,r8
        if_valid = 1'b1; if_pc = 32'h0000_0200; tick();
        inst_sram_rdata = 32'h0108_4821; rf[8] = 32'h0000_0033;
        fwd_waddr = {5'd0, 5'd8, 5'd8};
        fwd_wdata = {32'h0, 32'h0000_0022, 32'h0000_0011};
        fwd_we = 3'b011; #1;
        check("ld_valid", id_valid, 32'd1);
        check("ld_pc", id_pc, 32'h0000_0200);
        check("raddr1", rf_raddr1, 32'd8);
        check("fwd_ex_s1", src1_data, 32'h0000_0011);
        check("fwd_ex_s2", src2_data, 32'h0000_0011);
        fwd_we = 3'b010; #1;
        check("fwd_mem_s1", src1_data, 32'h0000_0022);
        check("fwd_mem_s2", src2_data, 32'h0000_0022);
        fwd_we = 3'b000; #1;
        check("fwd_rf_s1", src1_data, 32'h0000_0033);

        // r0 guard: addu r9,r0,r8 with a forward to r0
        if_pc = 32'h0000_0204; tick();
        inst_sram_rdata = 32'h0008_4821; rf[0] = 32'hA5A5_A5A5;
        fwd_waddr = 15'h0000; fwd_wdata = {32'h0, 32'h0, 32'hFFFF_FFFF}; fwd_we = 3'b001; #1;
        check("r0_guard", src1_data, 32'h0000_0000);
        check("r0_src2_rf", src2_data, 32'h0000_0033);
        rf[0] = 32'h0000_0000; fwd_we = 3'b000;

        // Load-use: addiu r6,r5,1 then lui r5
        if_pc = 32'h0000_0208; tick();
        inst_sram_rdata = 32'h24A6_0001; ex_is_load = 1'b1; ex_load_waddr = 5'd5; #1;
        check("lu_stallreq", stallreq, 32'd1);
        check("lu_br", br_taken, 32'd0);
        inst_sram_rdata = 32'h3C05_1234; #1;
        check("lui_nostall", stallreq, 32'd0);
        ex_is_load = 1'b0;

        // Stall hold across 3 cycles
        inst_sram_rdata = 32'h3C01_1234; stall = 6'b000110; #1;
        check("hold_c0", id_inst, 32'h3C01_1234);
        tick(); inst_sram_rdata = 32'hDEAD_BEEF; #1;
        check("hold_c1", id_inst, 32'h3C01_1234);
        tick(); #1;
        check("hold_c2", id_inst, 32'h3C01_1234);
        tick(); #1;
        check("hold_c3", id_inst, 32'h3C01_1234);
        check("hold_pc", id_pc, 32'h0000_0208);
        stall = 6'b000000; if_pc = 32'h0000_020C; tick();
        inst_sram_rdata = 32'h24A6_0001; #1;
        check("rel_inst", id_inst, 32'h24A6_0001);
        check("rel_pc", id_pc, 32'h0000_020C);

        // Branch: beq r1,r2,+3 at 0x100
        rf[1] = 32'd7; rf[2] = 32'd7; rf[31] = 32'h8000_0040;
        if_pc = 32'h0000_0100; tick();
        inst_sram_rdata = 32'h1022_0003; #1;
        check("beq_taken", br_taken, 32'd1);
        check("beq_tgt", br_target, 32'h0000_0110);
        check("beq_dslot", id_in_delay_slot, 32'd0);
        rf[2] = 32'd8; #1;
        check("beq_nt", br_taken, 32'd0);
        check("beq_nt_tgt", br_target, 32'd0);
        rf[2] = 32'd7; #1;
        if_pc = 32'h0000_0104; tick();
        inst_sram_rdata = 32'h03E0_0008; #1;
        check("ds_flag", id_in_delay_slot, 32'd1);
        check("jr_taken", br_taken, 32'd1);
        check("jr_tgt", br_target, 32'h8000_0040);
        if_pc = 32'hF000_0000; tick();
        inst_sram_rdata = 32'h0800_0040; #1;
        check("j_dslot", id_in_delay_slot, 32'd1);
        check("j_tgt", br_target, 32'hF000_0100);

        // Reset mid-stall
        stall = 6'b000110; tick();
        inst_sram_rdata = 32'hDEAD_BEEF; rst = 1'b1; tick();
        rst = 1'b0; #1;
        check("mrst_valid", id_valid, 32'd0);
        check("mrst_pc", id_pc, 32'd0);
        check("mrst_inst", id_inst, 32'd0);
        check("mrst_dslot", id_in_delay_slot, 32'd0);
        check("mrst_br", br_taken, 32'd0);
        stall = 6'b000000; if_pc = 32'h0000_0300; tick();
        inst_sram_rdata = 32'h3C01_1234; #1;
        check("post_rst_inst", id_inst, 32'h3C01_1234);
        check("post_rst_dslot", id_in_delay_slot, 32'd0);

        // Flush with stall[1]=0
        flush = 1'b1; if_pc = 32'h0000_0304; tick();
        flush = 1'b0; inst_sram_rdata = 32'h1022_0003; #1;
        check("flush_valid", id_valid, 32'd0);
        check("flush_br", br_taken, 32'd0);
        check("flush_inst", id_inst, 32'd0);

        // Flush during a stall
        if_pc = 32'h0000_0308; tick(); #1;
        check("pre_fs_valid", id_valid, 32'd1);
        stall = 6'b000110; flush = 1'b1; tick();
        flush = 1'b0; #1;
        check("fs_valid", id_valid, 32'd0);
        check("fs_pc", id_pc, 32'd0);

        // ID hold with EX running inserts a bubble
        stall = 6'b000000; if_pc = 32'h0000_030C; tick();
        stall = 6'b000010; tick(); #1;
        check("bubble_valid", id_valid, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
